// File: rtl/pixel_data_controller.sv
// rtl/pixel_data_controller.sv - active-window YCbCr 4:2:2 FIFO drain with RGB conversion and error flags
module pixel_data_controller #(
    parameter int H_START  = 1,
    parameter int H_ACTIVE = 1280,
    parameter int V_START  = 25,
    parameter int V_ACTIVE = 720,
    parameter int N_TILE   = 2,
    parameter int DW       = 8
) (
    input  logic              i_clk_74M,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic [11:0]       i_hcnt,
    input  logic [11:0]       i_vcnt,
    input  logic              i_fifo_empty,
    input  logic [12+2*DW:0]  i_data,
    output logic              o_fifo_read,
    output logic [DW-1:0]     o_r,
    output logic [DW-1:0]     o_g,
    output logic [DW-1:0]     o_b,
    output logic              o_de,
    output logic              o_underflow,
    output logic [15:0]       o_tag_err
);

    localparam int SW = DW + 12;
    localparam logic [11:0] H_LO   = 12'(H_START);
    localparam logic [11:0] H_HI   = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] V_LO   = 12'(V_START);
    localparam logic [11:0] V_HI   = 12'(V_START + V_ACTIVE);
    localparam logic [11:0] TILE_W = 12'(H_ACTIVE / N_TILE);
    localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};

    localparam logic [1:0] MODE_BLACK = 2'd0;
    localparam logic [1:0] MODE_TEST  = 2'd1;
    localparam logic [1:0] MODE_YCC   = 2'd2;
    localparam logic [1:0] MODE_LUMA  = 2'd3;

    localparam logic signed [SW-1:0] K_RV = SW'(359);
    localparam logic signed [SW-1:0] K_GU = SW'(-88);
    localparam logic signed [SW-1:0] K_GV = SW'(-183);
    localparam logic signed [SW-1:0] K_BU = SW'(454);

    logic [1:0]    in_tag;
    logic [DW-1:0] in_y;
    logic [DW-1:0] in_c;
    logic          unused_line;
    logic          win;
    logic [11:0]   p;
    logic [1:0]    exp_tile;
    logic [1:0]    mode_q;

    assign in_tag      = i_data[2*DW+12 -: 2];
    assign unused_line = ^i_data[2*DW+10 -: 11];
    assign in_y        = i_data[2*DW-1 -: DW];
    assign in_c        = i_data[DW-1:0];

    assign win = !i_rst && (i_hcnt >= H_LO) && (i_hcnt < H_HI)
                        && (i_vcnt >= V_LO) && (i_vcnt < V_HI);
    assign o_fifo_read = win && !i_fifo_empty;
    assign p           = i_hcnt - H_LO;
    assign exp_tile    = 2'(p / TILE_W);

    // Mode only changes at the frame origin so a frame is never mixed.
    always_ff @(posedge i_clk_74M) begin
        if (i_rst)
            mode_q <= MODE_BLACK;
        else if (i_hcnt == 12'd0 && i_vcnt == 12'd0)
            mode_q <= i_mode;
    end

    logic          s1_win, s1_empty, s1_odd, s1_first;
    logic [1:0]    s1_tag, s1_tile, s1_mode;
    logic [DW-1:0] s1_y, s1_c, s1_tp_g, s1_tp_b;

    always_ff @(posedge i_clk_74M) begin
        if (i_rst)
            s1_win <= 1'b0;
        else
            s1_win <= win;
        s1_empty <= i_fifo_empty;
        s1_tag   <= in_tag;
        s1_y     <= in_y;
        s1_c     <= in_c;
        s1_odd   <= p[0];
        s1_first <= (p == 12'd0);
        s1_tile  <= exp_tile;
        s1_mode  <= mode_q;
        s1_tp_g  <= i_vcnt[DW:1];
        s1_tp_b  <= i_hcnt[DW+1:2];
    end

    logic [DW-1:0] cb_q, cr_q, cb_base, cr_base, cb_now, cr_now;
    logic signed [SW-1:0] d_b, d_r, y_s;
    logic s1_valid;

    always_comb begin
        cb_base  = s1_first ? HALF : cb_q;
        cr_base  = s1_first ? HALF : cr_q;
        cb_now   = s1_odd ? cb_base : s1_c;
        cr_now   = s1_odd ? s1_c : cr_base;
        d_b      = $signed({{(SW-DW){1'b0}}, cb_now}) - $signed({{(SW-DW){1'b0}}, HALF});
        d_r      = $signed({{(SW-DW){1'b0}}, cr_now}) - $signed({{(SW-DW){1'b0}}, HALF});
        y_s      = $signed({{(SW-DW){1'b0}}, s1_y});
        s1_valid = s1_win && !s1_empty;
    end

    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            cb_q <= HALF;
            cr_q <= HALF;
        end else if (s1_valid) begin
            cb_q <= cb_now;
            cr_q <= cr_now;
        end else if (s1_win && s1_first) begin
            cb_q <= HALF;
            cr_q <= HALF;
        end
    end

    logic                 s2_win, s2_black;
    logic [1:0]           s2_mode;
    logic [DW-1:0]        s2_y, s2_tp_g, s2_tp_b;
    logic signed [SW-1:0] s2_r, s2_g, s2_b;
    logic                 tag_bad;

    assign tag_bad = s1_mode[1] && (s1_tag != s1_tile);

    always_ff @(posedge i_clk_74M) begin
        if (i_rst)
            s2_win <= 1'b0;
        else
            s2_win <= s1_win;
        s2_black <= s1_empty || tag_bad;
        s2_mode  <= s1_mode;
        s2_y     <= s1_y;
        s2_tp_g  <= s1_tp_g;
        s2_tp_b  <= s1_tp_b;
        s2_r     <= y_s + ((K_RV * d_r) >>> 8);
        s2_g     <= y_s + ((K_GU * d_b + K_GV * d_r) >>> 8);
        s2_b     <= y_s + ((K_BU * d_b) >>> 8);
    end

    // An empty slot has no meaningful tag, so only underflow is recorded.
    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            o_underflow <= 1'b0;
            o_tag_err   <= 16'd0;
        end else begin
            if (s1_win && s1_empty)
                o_underflow <= 1'b1;
            if (s1_valid && tag_bad && o_tag_err != 16'hFFFF)
                o_tag_err <= o_tag_err + 16'd1;
        end
    end

    function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return '0;
        else if (|v[SW-2:DW])
            return '1;
        else
            return v[DW-1:0];
    endfunction

    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            o_de <= 1'b0;
            o_r  <= '0;
            o_g  <= '0;
            o_b  <= '0;
        end else begin
            o_de <= s2_win;
            if (!s2_win || s2_black) begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end else begin
                case (s2_mode)
                    MODE_BLACK: begin o_r <= '0;          o_g <= '0;          o_b <= '0;          end
                    MODE_TEST:  begin o_r <= '0;          o_g <= s2_tp_g;     o_b <= s2_tp_b;     end
                    MODE_YCC:   begin o_r <= clamp(s2_r); o_g <= clamp(s2_g); o_b <= clamp(s2_b); end
                    MODE_LUMA:  begin o_r <= s2_y;        o_g <= s2_y;        o_b <= s2_y;        end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_data_controller.sv
// tb/tb_pixel_data_controller.sv - directed self-checking bench for pixel_data_controller
module tb_pixel_data_controller;

    localparam int HS     = 1;
    localparam int HA     = 1280;
    localparam int LAST_H = HS + HA + 2;

    logic        i_clk_74M = 1'b0;
    logic        i_rst;
    logic [1:0]  i_mode;
    logic [11:0] i_hcnt, i_vcnt;
    logic        i_fifo_empty;
    logic [28:0] i_data;
    logic        o_fifo_read, o_de, o_underflow;
    logic [7:0]  o_r, o_g, o_b;
    logic [15:0] o_tag_err;

    always #7 i_clk_74M = ~i_clk_74M;

    pixel_data_controller #(
        .H_START(1), .H_ACTIVE(1280), .V_START(25), .V_ACTIVE(720), .N_TILE(2), .DW(8)
    ) dut (
        .i_clk_74M   (i_clk_74M),
        .i_rst       (i_rst),
        .i_mode      (i_mode),
        .i_hcnt      (i_hcnt),
        .i_vcnt      (i_vcnt),
        .i_fifo_empty(i_fifo_empty),
        .i_data      (i_data),
        .o_fifo_read (o_fifo_read),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b),
        .o_de        (o_de),
        .o_underflow (o_underflow),
        .o_tag_err   (o_tag_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  ly [HA];
    logic [7:0]  lc [HA];
    logic [1:0]  lt [HA];
    logic        le [HA];
    logic [7:0]  er [HA];
    logic [7:0]  eg [HA];
    logic [7:0]  eb [HA];
    logic [24:0] got    [LAST_H+1];
    logic        got_rd [LAST_H+1];

    task automatic tick();
        @(posedge i_clk_74M);
        #1;
    endtask

    task automatic set_in(input int h, input int v, input logic empty, input logic [1:0] tag,
                          input logic [7:0] y, input logic [7:0] c);
        i_hcnt       = 12'(h);
        i_vcnt       = 12'(v);
        i_fifo_empty = empty;
        i_data       = {tag, 11'(v), y, c};
    endtask

    task automatic frame_origin(input logic [1:0] m);
        i_mode = m;
        set_in(0, 0, 1'b1, 2'd0, 8'd0, 8'd0);
        tick();
    endtask

    // Default line: correct tile tags, constant Y/C, grey expected output.
    task automatic fill_line(input logic [7:0] y, input logic [7:0] c);
        for (int p = 0; p < HA; p++) begin
            ly[p] = y; lc[p] = c; lt[p] = 2'(p / (HA / 2)); le[p] = 1'b0;
            er[p] = y; eg[p] = y; eb[p] = y;
        end
    endtask

    task automatic run_line(input int v);
        for (int i = 0; i <= LAST_H + 2; i++) begin
            int p = i - HS;
            if (p >= 0 && p < HA)
                set_in(i, v, le[p], lt[p], ly[p], lc[p]);
            else
                set_in(i, v, 1'b0, 2'd0, 8'd0, 8'd0);
            #1;
            if (i <= LAST_H) got_rd[i] = o_fifo_read;
            tick();
            if (i >= 2) got[i-2] = {o_de, o_r, o_g, o_b};
        end
    endtask

    function automatic logic [24:0] exp_px(input int h);
        int p = h - HS;
        if (p >= 0 && p < HA) return {1'b1, er[p], eg[p], eb[p]};
        return 25'd0;
    endfunction

    function automatic logic exp_rd(input int h);
        int p = h - HS;
        if (p >= 0 && p < HA) return !le[p];
        return 1'b0;
    endfunction

    task automatic test_reset();
        i_rst = 1'b1;
        i_mode = 2'd2;
        set_in(5, 30, 1'b0, 2'd0, 8'd128, 8'd128);
        repeat (3) tick();
        n_cmp++;
        if (o_fifo_read !== 1'b0) begin n_bad++; $display("FAIL reset_read got=%b exp=0", o_fifo_read); end
        n_cmp++;
        if ({o_de, o_r, o_g, o_b} !== 25'd0) begin n_bad++; $display("FAIL reset_px got=%h exp=0", {o_de, o_r, o_g, o_b}); end
        n_cmp++;
        if (o_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_uf got=%b exp=0", o_underflow); end
        n_cmp++;
        if (o_tag_err !== 16'd0) begin n_bad++; $display("FAIL reset_tag got=%0d exp=0", o_tag_err); end
        i_rst = 1'b0;
    endtask

    task automatic test_neutral();
        int nrd = 0;
        frame_origin(2'd2);
        fill_line(8'd128, 8'd128);
        run_line(25);
        for (int h = 0; h <= LAST_H; h++) begin
            nrd += int'(got_rd[h]);
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL neutral h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
        n_cmp++;
        if (nrd != 1280) begin n_bad++; $display("FAIL neutral_reads got=%0d exp=1280", nrd); end
    endtask

    task automatic test_colour();
        fill_line(8'd128, 8'd128);
        ly[21] = 8'd200; lc[21] = 8'd160; er[21] = 8'd244; eg[21] = 8'd177; eb[21] = 8'd200;
        er[22] = 8'd172; eg[22] = 8'd105; eb[22] = 8'd128;
        lc[1279] = 8'd160; er[1279] = 8'd172; eg[1279] = 8'd105; eb[1279] = 8'd128;
        run_line(26);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL colour h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
    endtask

    task automatic test_clamp();
        fill_line(8'd128, 8'd128);
        ly[0]  = 8'd100;  er[0]  = 8'd100; eg[0]  = 8'd100; eb[0]  = 8'd100;
        ly[30] = 8'd0;    er[30] = 8'd0;   eg[30] = 8'd0;   eb[30] = 8'd0;
        ly[31] = 8'd0;    lc[31] = 8'd0;   er[31] = 8'd0;   eg[31] = 8'd91;  eb[31] = 8'd0;
        ly[32] = 8'd255;  er[32] = 8'd75;  eg[32] = 8'd255; eb[32] = 8'd255;
        ly[33] = 8'd255;  lc[33] = 8'd255; er[33] = 8'd255; eg[33] = 8'd164; eb[33] = 8'd255;
        ly[34] = 8'd0;    lc[34] = 8'd255; er[34] = 8'd178; eg[34] = 8'd0;   eb[34] = 8'd225;
        ly[35] = 8'd0;    lc[35] = 8'd255; er[35] = 8'd178; eg[35] = 8'd0;   eb[35] = 8'd225;
        er[36] = 8'd255;  eg[36] = 8'd37;  eb[36] = 8'd128;
        run_line(27);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL clamp h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
    endtask

    task automatic test_underflow();
        n_cmp++;
        if (o_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_before got=%b exp=0", o_underflow); end
        fill_line(8'd128, 8'd128);
        for (int p = 100; p <= 104; p++) begin
            le[p] = 1'b1; er[p] = 8'd0; eg[p] = 8'd0; eb[p] = 8'd0;
        end
        le[200] = 1'b1; lt[200] = 2'd3; er[200] = 8'd0; eg[200] = 8'd0; eb[200] = 8'd0;
        run_line(28);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL underflow h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
        n_cmp++;
        if (o_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set got=%b exp=1", o_underflow); end
        n_cmp++;
        if (o_tag_err !== 16'd0) begin n_bad++; $display("FAIL uf_tag got=%0d exp=0", o_tag_err); end
        fill_line(8'd128, 8'd128);
        run_line(29);
        n_cmp++;
        if (o_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got=%b exp=1", o_underflow); end
    endtask

    task automatic test_tags();
        fill_line(8'd128, 8'd128);
        lt[10] = 2'd1; er[10] = 8'd0; eg[10] = 8'd0; eb[10] = 8'd0;
        run_line(30);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL tags h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
        n_cmp++;
        if (o_tag_err !== 16'd1) begin n_bad++; $display("FAIL tag_count got=%0d exp=1", o_tag_err); end
    endtask

    task automatic test_mode_switch();
        i_mode = 2'd1;
        fill_line(8'd128, 8'd128);
        run_line(31);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h)) begin
                n_bad++;
                $display("FAIL mode_hold h=%0d px=%h exp px=%h", h, got[h], exp_px(h));
            end
        end
        frame_origin(2'd1);
        fill_line(8'd77, 8'd200);
        lt[5] = 2'd3;
        for (int p = 0; p < HA; p++) begin
            er[p] = 8'd0; eg[p] = 8'd20; eb[p] = 8'((p + HS) >> 2);
        end
        run_line(40);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL pattern h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
        n_cmp++;
        if (o_tag_err !== 16'd1) begin n_bad++; $display("FAIL pattern_tag got=%0d exp=1", o_tag_err); end
    endtask

    task automatic test_luma();
        frame_origin(2'd3);
        fill_line(8'd0, 8'd0);
        for (int p = 0; p < HA; p++) begin
            ly[p] = 8'(p * 7); lc[p] = 8'(p * 13);
            er[p] = ly[p]; eg[p] = ly[p]; eb[p] = ly[p];
        end
        lt[50] = 2'd1; er[50] = 8'd0; eg[50] = 8'd0; eb[50] = 8'd0;
        run_line(41);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL luma h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
        n_cmp++;
        if (o_tag_err !== 16'd2) begin n_bad++; $display("FAIL luma_tag got=%0d exp=2", o_tag_err); end
    endtask

    task automatic test_reset_midline();
        for (int h = 1; h <= 300; h++) begin
            set_in(h, 42, 1'b0, 2'd0, 8'd60, 8'd128);
            tick();
        end
        i_rst = 1'b1;
        for (int h = 301; h <= 303; h++) begin
            set_in(h, 42, 1'b0, 2'd0, 8'd60, 8'd128);
            #1;
            n_cmp++;
            if (o_fifo_read !== 1'b0) begin n_bad++; $display("FAIL rst_mid_read h=%0d got=%b exp=0", h, o_fifo_read); end
            tick();
        end
        n_cmp++;
        if ({o_de, o_r, o_g, o_b, o_underflow, o_tag_err} !== 42'd0)
            begin n_bad++; $display("FAIL rst_mid_state got=%h exp=0", {o_de, o_r, o_g, o_b, o_underflow, o_tag_err}); end
        set_in(0, 43, 1'b0, 2'd0, 8'd0, 8'd0);
        i_rst = 1'b0;
        fill_line(8'd90, 8'd128);
        for (int p = 0; p < HA; p++) begin
            er[p] = 8'd0; eg[p] = 8'd0; eb[p] = 8'd0;
        end
        run_line(43);
        for (int h = 0; h <= LAST_H; h++) begin
            n_cmp++;
            if (got[h] !== exp_px(h) || got_rd[h] !== exp_rd(h)) begin
                n_bad++;
                $display("FAIL rst_mode0 h=%0d px=%h rd=%b exp px=%h rd=%b", h, got[h], got_rd[h], exp_px(h), exp_rd(h));
            end
        end
    endtask

    initial begin
        test_reset();
        test_neutral();
        test_colour();
        test_clamp();
        test_underflow();
        test_tags();
        test_mode_switch();
        test_luma();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
